// File: rtl/pong_round_ctrl_if.sv
// Signal bundle between the round controller and the keyboard decode and ball block.
// The master side drives keys and ball position. The slave side is the controller.
interface pong_round_ctrl_if;
  logic       start;
  logic       pause;
  logic [9:0] ball_x;
  logic [9:0] ball_s;
  logic       ball_reset;
  logic       ball_run;
  logic       serve_dir;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] winner;
  logic [2:0] state;

  modport master (
    output start, pause, ball_x, ball_s,
    input  ball_reset, ball_run, serve_dir, score_l, score_r, winner, state
  );

  modport slave (
    input  start, pause, ball_x, ball_s,
    output ball_reset, ball_run, serve_dir, score_l, score_r, winner, state
  );
endinterface

// File: rtl/pong_round_ctrl.sv
// Frame-rate Pong round sequencer: serve countdown, play, point freeze, pause and game over.
// All outputs are decoded from registers, so there is no path from the inputs to the outputs.
module pong_round_ctrl #(
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 7
) (
  input  logic             frame_clk,
  input  logic             Reset,
  pong_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    POINT  = 3'd3,
    PAUSED = 3'd4,
    OVER   = 3'd5
  } state_t;

  localparam logic [10:0] X_MIN_W    = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W    = 11'(X_MAX);
  localparam logic [7:0]  SERVE_LOAD = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]  POINT_LOAD = 8'(POINT_FRAMES - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [3:0]  score_l_reg, score_l_next;
  logic [3:0]  score_r_reg, score_r_next;
  logic [1:0]  winner_reg, winner_next;
  logic        serve_dir_reg, serve_dir_next;
  logic        start_q_reg, pause_q_reg;

  logic        start_ev, pause_ev;
  logic [10:0] right_edge;
  logic        right_miss, left_miss;

  assign start_ev   = bus.start & ~start_q_reg;
  assign pause_ev   = bus.pause & ~pause_q_reg;
  // Widening to 11 bits keeps ball_x + ball_s from wrapping near the right wall.
  assign right_edge = {1'b0, bus.ball_x} + {1'b0, bus.ball_s};
  assign right_miss = right_edge >= X_MAX_W;
  assign left_miss  = {1'b0, bus.ball_x} <= (X_MIN_W + {1'b0, bus.ball_s});

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      score_l_reg   <= '0;
      score_r_reg   <= '0;
      winner_reg    <= 2'b00;
      serve_dir_reg <= 1'b0;
      // Forcing the edge detectors high means a key held through reset does not count as a press.
      start_q_reg   <= 1'b1;
      pause_q_reg   <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      score_l_reg   <= score_l_next;
      score_r_reg   <= score_r_next;
      winner_reg    <= winner_next;
      serve_dir_reg <= serve_dir_next;
      start_q_reg   <= bus.start;
      pause_q_reg   <= bus.pause;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    score_l_next   = score_l_reg;
    score_r_next   = score_r_reg;
    winner_next    = winner_reg;
    serve_dir_next = serve_dir_reg;

    case (state_reg)
      IDLE: begin
        score_l_next = '0;
        score_r_next = '0;
        winner_next  = 2'b00;
        if (start_ev) begin
          cnt_next   = SERVE_LOAD;
          state_next = SERVE;
        end
      end
      SERVE: begin
        if (cnt_reg == 8'd0) state_next = PLAY;
        else                 cnt_next   = cnt_reg - 8'd1;
      end
      PLAY: begin
        // A miss wins over a pause press that arrives in the same frame.
        if (right_miss) begin
          if (score_l_reg != 4'd15) score_l_next = score_l_reg + 4'd1;
          serve_dir_next = 1'b1;
          cnt_next       = POINT_LOAD;
          state_next     = POINT;
        end else if (left_miss) begin
          if (score_r_reg != 4'd15) score_r_next = score_r_reg + 4'd1;
          serve_dir_next = 1'b0;
          cnt_next       = POINT_LOAD;
          state_next     = POINT;
        end else if (pause_ev) begin
          state_next = PAUSED;
        end
      end
      POINT: begin
        if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else if (score_l_reg == WIN) begin
          winner_next = 2'b01;
          state_next  = OVER;
        end else if (score_r_reg == WIN) begin
          winner_next = 2'b10;
          state_next  = OVER;
        end else begin
          cnt_next   = SERVE_LOAD;
          state_next = SERVE;
        end
      end
      PAUSED: begin
        if (pause_ev) state_next = PLAY;
      end
      OVER: begin
        if (start_ev) begin
          score_l_next = '0;
          score_r_next = '0;
          winner_next  = 2'b00;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.ball_reset = (state_reg == IDLE) || (state_reg == SERVE);
  assign bus.ball_run   = (state_reg == PLAY);
  assign bus.serve_dir  = serve_dir_reg;
  assign bus.score_l    = score_l_reg;
  assign bus.score_r    = score_r_reg;
  assign bus.winner     = winner_reg;
  assign bus.state      = state_reg;

endmodule

// File: tb/tb_pong_round_ctrl.sv
// Scoreboard bench for pong_round_ctrl: each frame pushes the expected registers,
// and the entry is popped and compared one clock edge later.
module tb_pong_round_ctrl;
  localparam int SERVE_FRAMES = 60;
  localparam int POINT_FRAMES = 90;
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_PAUSED = 4, S_OVER = 5;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;

  pong_round_ctrl_if bus ();

  pong_round_ctrl #(
    .X_MIN(0), .X_MAX(639), .SERVE_FRAMES(SERVE_FRAMES),
    .POINT_FRAMES(POINT_FRAMES), .WIN_SCORE(7)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(bus.slave)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    string tag;
    int    st;
    int    sl;
    int    sr;
    int    win;
    int    dir;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One frame: drive inputs, queue the expectation, clock once, pop and compare.
  task automatic frame(input logic st_in, input logic pa_in, input int x, input int s,
                       input string tag, input int st, input int sl, input int sr,
                       input int win, input int dir);
    exp_t e;
    bus.start  = st_in;
    bus.pause  = pa_in;
    bus.ball_x = 10'(x);
    bus.ball_s = 10'(s);
    e.tag = tag; e.st = st; e.sl = sl; e.sr = sr; e.win = win; e.dir = dir;
    sb.push_back(e);
    @(posedge frame_clk);
    #1;
    e = sb.pop_front();
    txn++;
    check_val({e.tag, ".state"},   32'(bus.state),     e.st);
    check_val({e.tag, ".score_l"}, 32'(bus.score_l),   e.sl);
    check_val({e.tag, ".score_r"}, 32'(bus.score_r),   e.sr);
    check_val({e.tag, ".winner"},  32'(bus.winner),    e.win);
    check_val({e.tag, ".dir"},     32'(bus.serve_dir), e.dir);
    check_val({e.tag, ".reset"},   32'(bus.ball_reset), (e.st == S_IDLE || e.st == S_SERVE) ? 1 : 0);
    check_val({e.tag, ".run"},     32'(bus.ball_run),   (e.st == S_PLAY) ? 1 : 0);
    $display("txn %0d %s state=%0d score=%0d/%0d win=%0d dir=%0d",
             txn, e.tag, bus.state, bus.score_l, bus.score_r, bus.winner, bus.serve_dir);
  endtask

  // Starting from the edge that entered SERVE: SERVE_FRAMES-1 more SERVE frames, then PLAY.
  task automatic serve_to_play(input logic st_in, input int sl, input int sr, input int dir);
    for (int i = 0; i < SERVE_FRAMES - 1; i++)
      frame(st_in, 1'b0, 320, 4, "serve", S_SERVE, sl, sr, 0, dir);
    frame(st_in, 1'b0, 320, 4, "release", S_PLAY, sl, sr, 0, dir);
  endtask

  task automatic point_wait(input int sl, input int sr, input int dir, input int last_st, input int win);
    for (int i = 0; i < POINT_FRAMES - 1; i++)
      frame(1'b0, 1'b0, 320, 4, "point", S_POINT, sl, sr, 0, dir);
    frame(1'b0, 1'b0, 320, 4, "point_end", last_st, sl, sr, win, dir);
  endtask

  task automatic miss_cycle(input int x, input int sl, input int sr, input int dir);
    frame(1'b0, 1'b0, x, 4, "miss", S_POINT, sl, sr, 0, dir);
    point_wait(sl, sr, dir, S_SERVE, 0);
    serve_to_play(1'b0, sl, sr, dir);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start  = 1'b1;
    bus.pause  = 1'b0;
    bus.ball_x = 10'd320;
    bus.ball_s = 10'd4;
    #3;
    check_val("rst.state", 32'(bus.state), S_IDLE);
    check_val("rst.reset", 32'(bus.ball_reset), 1);
    check_val("rst.run",   32'(bus.ball_run), 0);
    check_val("rst.dir",   32'(bus.serve_dir), 0);
    #7 Reset = 1'b0;

    // Start held through reset is not a press; a fresh press starts the serve.
    frame(1'b1, 1'b0, 320, 4, "held", S_IDLE, 0, 0, 0, 0);
    frame(1'b0, 1'b0, 320, 4, "release", S_IDLE, 0, 0, 0, 0);
    frame(1'b1, 1'b0, 320, 4, "start", S_SERVE, 0, 0, 0, 0);
    serve_to_play(1'b1, 0, 0, 0);

    // Right miss, then left misses at the boundary, then a non-miss.
    frame(1'b0, 1'b0, 636, 4, "rmiss", S_POINT, 1, 0, 0, 1);
    point_wait(1, 0, 1, S_SERVE, 0);
    serve_to_play(1'b0, 1, 0, 1);
    miss_cycle(3, 1, 1, 0);
    miss_cycle(4, 1, 2, 0);
    frame(1'b0, 1'b0, 5, 4, "no_lmiss", S_PLAY, 1, 2, 0, 0);
    frame(1'b0, 1'b0, 634, 4, "no_rmiss", S_PLAY, 1, 2, 0, 0);

    // Pause masks misses and start presses; resuming scores the miss on the next edge.
    frame(1'b0, 1'b1, 320, 4, "pause", S_PAUSED, 1, 2, 0, 0);
    for (int i = 0; i < 10; i++)
      frame(1'b1, 1'b1, 636, 4, "paused_miss", S_PAUSED, 1, 2, 0, 0);
    frame(1'b0, 1'b0, 636, 4, "paused", S_PAUSED, 1, 2, 0, 0);
    frame(1'b0, 1'b1, 636, 4, "resume", S_PLAY, 1, 2, 0, 0);
    frame(1'b0, 1'b1, 636, 4, "late_miss", S_POINT, 2, 2, 0, 1);
    point_wait(2, 2, 1, S_SERVE, 0);
    serve_to_play(1'b0, 2, 2, 1);

    // Left player runs to 7; the final miss coincides with a pause press.
    for (int sl = 3; sl <= 7; sl++) begin
      frame(1'b0, (sl == 7), 636, 4, "rmiss", S_POINT, sl, 2, 0, 1);
      if (sl < 7) begin
        point_wait(sl, 2, 1, S_SERVE, 0);
        serve_to_play(1'b0, sl, 2, 1);
      end else begin
        point_wait(7, 2, 1, S_OVER, 1);
      end
    end
    frame(1'b0, 1'b0, 320, 4, "over", S_OVER, 7, 2, 1, 1);
    frame(1'b0, 1'b1, 320, 4, "over_pause", S_OVER, 7, 2, 1, 1);
    frame(1'b1, 1'b0, 320, 4, "restart", S_IDLE, 0, 0, 0, 1);

    // Build a 3/2 score, then assert reset mid-point with cnt at 40.
    frame(1'b0, 1'b0, 320, 4, "idle", S_IDLE, 0, 0, 0, 1);
    frame(1'b1, 1'b0, 320, 4, "start2", S_SERVE, 0, 0, 0, 1);
    serve_to_play(1'b0, 0, 0, 1);
    miss_cycle(635, 1, 0, 1);
    miss_cycle(2, 1, 1, 0);
    miss_cycle(636, 2, 1, 1);
    miss_cycle(0, 2, 2, 0);
    frame(1'b0, 1'b0, 636, 4, "rmiss", S_POINT, 3, 2, 0, 1);
    for (int i = 0; i < POINT_FRAMES - 1 - 40; i++)
      frame(1'b0, 1'b0, 320, 4, "point", S_POINT, 3, 2, 0, 1);
    #2 Reset = 1'b1;
    #1;
    check_val("async_rst.state",   32'(bus.state), S_IDLE);
    check_val("async_rst.score_l", 32'(bus.score_l), 0);
    check_val("async_rst.score_r", 32'(bus.score_r), 0);
    check_val("async_rst.reset",   32'(bus.ball_reset), 1);
    check_val("async_rst.run",     32'(bus.ball_run), 0);
    check_val("async_rst.dir",     32'(bus.serve_dir), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
